// File: rtl/bus_timer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL bit indices,
// read FSM encoding and the byte-lane merge helper.
package bus_timer_pkg;

    localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] OFF_CTRL        = 8'h10;
    localparam logic [7:0] OFF_PRESCALE    = 8'h14;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rd_state_e;

    // Replace only the byte lanes selected by be; the rest keep old_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every PRESCALE+1 enabled clocks.
// clear restarts the count from zero (used when software rewrites PRESCALE).
module timer_prescaler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [31:0] prescale,
    input  logic        clear,
    output logic        tick
);

    logic [31:0] count;

    assign tick = enable & (count == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd0;
        end else if (clear) begin
            count <= 32'd0;
        end else if (enable) begin
            count <= tick ? 32'd0 : count + 32'd1;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, CTRL and PRESCALE registers,
// two-cycle reads through a small FSM, and a registered level interrupt.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [31:0] PRESCALE_RESET = 32'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  select,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic [31:0]           bus_write_data,
    input  logic [3:0]            bus_byte_enable,
    input  logic                  bus_write_enable,
    input  logic                  bus_read_enable,
    output logic [31:0]           bus_read_data,
    output logic                  bus_busy,
    output logic                  timer_interrupt_request
);

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK   = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_MTIME_LO  = ADDR_WIDTH'(OFF_MTIME_LO);
    localparam logic [ADDR_WIDTH-1:0] A_MTIME_HI  = ADDR_WIDTH'(OFF_MTIME_HI);
    localparam logic [ADDR_WIDTH-1:0] A_CMP_LO    = ADDR_WIDTH'(OFF_MTIMECMP_LO);
    localparam logic [ADDR_WIDTH-1:0] A_CMP_HI    = ADDR_WIDTH'(OFF_MTIMECMP_HI);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL      = ADDR_WIDTH'(OFF_CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_PRESCALE  = ADDR_WIDTH'(OFF_PRESCALE);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [1:0]  ctrl;
    logic [31:0] prescale;
    logic        tick;

    rd_state_e   state;
    rd_state_e   state_next;
    logic        busy_comb;
    logic        capture;

    logic [ADDR_WIDTH-1:0] word_addr;
    logic        is_write;
    logic        is_read;
    logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_prescale;
    logic [63:0] mtime_inc;
    logic [31:0] read_mux;

    // Both enables high counts as a store, so a read is only a read without we.
    assign word_addr = bus_address & WORD_MASK;
    assign is_write  = select & bus_write_enable;
    assign is_read   = select & bus_read_enable & ~bus_write_enable;

    assign wr_mtime_lo = is_write & (word_addr == A_MTIME_LO);
    assign wr_mtime_hi = is_write & (word_addr == A_MTIME_HI);
    assign wr_cmp_lo   = is_write & (word_addr == A_CMP_LO);
    assign wr_cmp_hi   = is_write & (word_addr == A_CMP_HI);
    assign wr_ctrl     = is_write & (word_addr == A_CTRL);
    assign wr_prescale = is_write & (word_addr == A_PRESCALE);

    timer_prescaler u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (ctrl[CTRL_EN_BIT]),
        .prescale (prescale),
        .clear    (wr_prescale),
        .tick     (tick)
    );

    // Software writes land on top of the incremented value so a tick is never lost.
    assign mtime_inc = tick ? mtime + 64'd1 : mtime;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime    <= 64'd0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl     <= 2'b11;
            prescale <= PRESCALE_RESET;
        end else begin
            mtime[31:0]  <= wr_mtime_lo ? merge_bytes(mtime_inc[31:0], bus_write_data, bus_byte_enable)
                                        : mtime_inc[31:0];
            mtime[63:32] <= wr_mtime_hi ? merge_bytes(mtime_inc[63:32], bus_write_data, bus_byte_enable)
                                        : mtime_inc[63:32];
            if (wr_cmp_lo) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], bus_write_data, bus_byte_enable);
            if (wr_cmp_hi) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus_write_data, bus_byte_enable);
            if (wr_ctrl && bus_byte_enable[0]) ctrl <= bus_write_data[1:0];
            if (wr_prescale) prescale <= merge_bytes(prescale, bus_write_data, bus_byte_enable);
        end
    end

    always_comb begin
        read_mux = 32'd0;
        case (word_addr)
            A_MTIME_LO: read_mux = mtime[31:0];
            A_MTIME_HI: read_mux = mtime[63:32];
            A_CMP_LO:   read_mux = mtimecmp[31:0];
            A_CMP_HI:   read_mux = mtimecmp[63:32];
            A_CTRL:     read_mux = {30'd0, ctrl};
            A_PRESCALE: read_mux = prescale;
            default:    read_mux = 32'd0;
        endcase
    end

    // Read handshake: busy is high for the IDLE request cycle only; data is
    // captured at that edge and presented (busy low) during RESP.
    always_comb begin
        state_next = state;
        busy_comb  = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (is_read) begin
                    busy_comb  = 1'b1;
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Gated with rst_n so a read caught by reset releases the core at once.
    assign bus_busy = busy_comb & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= ST_IDLE;
            bus_read_data           <= 32'd0;
            timer_interrupt_request <= 1'b0;
        end else begin
            state                   <= state_next;
            if (capture) bus_read_data <= read_mux;
            timer_interrupt_request <= ctrl[CTRL_IRQ_EN_BIT] & (mtime >= mtimecmp);
        end
    end

endmodule
